fetch_queue_unit: RTL and testbench

- Instruction-fetch front end sitting directly upstream of Decoder_Controller. It replaces the combinational PC_unit/Instruction_Memory coupling with a registered PC.
- Issues one-at-a-time fetch requests to an instruction memory with variable latency.
- Buffers returned instructions, with their PCs, in a small FIFO drained by the decoder through a valid/ready handshake.
- Branch/jump redirects from the execute side flush the queue and restart fetch.

---
 rtl/fetch_queue_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: registered PC, one outstanding imem request,
// and a small PC+instruction FIFO drained by the decoder. Redirects flush and refetch.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst_data,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] queue_count
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 pc_q, pc_d;
  logic [31:0]                 drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [31:0]                 inst_pc_q, inst_pc_d, inst_data_q, inst_data_d;
  logic [DEPTH-1:0][31:0]      ent_pc_q, ent_pc_d, ent_data_q, ent_data_d;

  logic [31:0]                 redir_pc;
  logic                        push, pop;
  logic [CNT_W-1:0]            cnt_after_pop;

  always_comb begin
    redir_pc      = redirect_pc & 32'hFFFF_FFFC;
    pop           = (count_q != '0) && inst_ready;
    push          = (state_q == REQ) && imem_ack && !redirect_valid;
    cnt_after_pop = count_q - CNT_W'(pop);
    count_d       = redirect_valid ? '0 : cnt_after_pop + CNT_W'(push);
  end

  // Fetch FSM: a request, once raised, holds its address until acked.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (count_d < FULL) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (!imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (count_d >= FULL) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ent_pc_d   = ent_pc_q;
    ent_data_d = ent_data_q;
    if (push) begin
      ent_pc_d[wr_ptr_q]   = pc_q;
      ent_data_d[wr_ptr_q] = imem_rdata;
    end
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  // Head registers are loaded with the next head so the decoder sees pure flop outputs;
  // a push into an otherwise empty queue bypasses storage to meet the 1-cycle latency.
  always_comb begin
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    if (count_d != '0) begin
      if (cnt_after_pop == '0) begin
        inst_pc_d   = pc_q;
        inst_data_d = imem_rdata;
      end else begin
        inst_pc_d   = ent_pc_q[rd_ptr_d];
        inst_data_d = ent_data_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inst_pc_q    <= '0;
      inst_data_q  <= '0;
      ent_pc_q     <= '0;
      ent_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_pc_q    <= inst_pc_d;
      inst_data_q  <= inst_data_d;
      ent_pc_q     <= ent_pc_d;
      ent_data_q   <= ent_data_d;
    end
  end

  always_comb begin
    imem_req  = (state_q != IDLE);
    imem_addr = (state_q == REQ)   ? pc_q :
                (state_q == DRAIN) ? drain_addr_q : 32'h0;
  end

  assign inst_valid  = (count_q != '0);
  assign inst_pc     = inst_pc_q;
  assign inst_data   = inst_data_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: expected decoder-side entries go into a
// scoreboard queue; a negedge monitor compares every accepted head against it.
module tb_fetch_queue_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b1;
  logic [2:0]  queue_count;
  logic        ack_en = 1'b1;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   npop  = 0;

  fetch_queue_unit #(.RESET_PC(32'h0), .DEPTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
    .inst_ready(inst_ready), .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  // Memory model: instruction word is the address xor a fixed tag.
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
    ent_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic restart(input logic ready);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    inst_ready     = ready;
    ack_en         = 1'b1;
    exp_q.delete();
    npop           = 0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Monitor: a head accepted under a redirect is flushed, so it is not scored.
  always @(negedge clock) begin
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc %h, nothing expected", inst_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_pc", inst_pc, e.pc);
        chk("pop_data", inst_data, e.data);
        npop++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick;
    tick;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_count", {29'b0, queue_count}, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // Streaming with ack and ready held high
    reset = 1'b0;
    push_exp(32'h0, 32'hDEAD_0000);
    push_exp(32'h4, 32'hDEAD_0004);
    push_exp(32'h8, 32'hDEAD_0008);
    push_exp(32'hC, 32'hDEAD_000C);
    tick; chk("a_req", {31'b0, imem_req}, 32'h1); chk("a_addr0", imem_addr, 32'h0);
    tick; chk("a_addr4", imem_addr, 32'h4);
    tick; chk("a_addr8", imem_addr, 32'h8);
    tick; chk("a_addrC", imem_addr, 32'hC);
    tick; chk("a_npop", npop, 3); chk("a_head", inst_pc, 32'hC);
    chk("a_count", {29'b0, queue_count}, 32'h1);
    // Asynchronous reset between clock edges
    reset = 1'b1;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'h0);
    chk("async_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_count", {29'b0, queue_count}, 32'h0);

    // Fill with decoder stalled, then a single pop
    restart(1'b0);
    tick; tick; tick; tick; tick;
    chk("b_count4", {29'b0, queue_count}, 32'h4);
    chk("b_req0", {31'b0, imem_req}, 32'h0);
    chk("b_head_pc", inst_pc, 32'h0);
    chk("b_head_data", inst_data, 32'hDEAD_0000);
    tick;
    chk("b_idle_req", {31'b0, imem_req}, 32'h0);
    push_exp(32'h0, 32'hDEAD_0000);
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    chk("b_count3", {29'b0, queue_count}, 32'h3);
    chk("b_req1", {31'b0, imem_req}, 32'h1);
    chk("b_addr10", imem_addr, 32'h10);
    chk("b_head4", inst_pc, 32'h4);
    chk("b_npop", npop, 1);
    tick;
    chk("b_refull", {29'b0, queue_count}, 32'h4);
    chk("b_req_off", {31'b0, imem_req}, 32'h0);

    // Ack delayed three cycles on 0x8
    restart(1'b0);
    tick; tick; tick;
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("c_wait_req", {31'b0, imem_req}, 32'h1);
      chk("c_wait_addr", imem_addr, 32'h8);
      chk("c_wait_count", {29'b0, queue_count}, 32'h2);
    end
    ack_en = 1'b1;
    tick;
    ack_en = 1'b0;
    chk("c_count3", {29'b0, queue_count}, 32'h3);
    chk("c_addrC", imem_addr, 32'hC);
    tick;
    chk("c_one_push", {29'b0, queue_count}, 32'h3);

    // Redirect while 0x8 is outstanding with two queued entries
    restart(1'b0);
    tick; tick; tick;
    ack_en = 1'b0;
    chk("d_pre_count", {29'b0, queue_count}, 32'h2);
    chk("d_pre_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    exp_q.delete();
    tick;
    redirect_valid = 1'b0;
    chk("d_flush_count", {29'b0, queue_count}, 32'h0);
    chk("d_flush_valid", {31'b0, inst_valid}, 32'h0);
    chk("d_drain_req", {31'b0, imem_req}, 32'h1);
    chk("d_drain_addr", imem_addr, 32'h8);
    tick;
    chk("d_drain_hold", imem_addr, 32'h8);
    ack_en = 1'b1;
    tick;
    chk("d_discard", {29'b0, queue_count}, 32'h0);
    chk("d_new_addr", imem_addr, 32'h100);
    push_exp(32'h100, 32'hDEAD_0100);
    inst_ready = 1'b1;
    tick;
    chk("d_first_pc", inst_pc, 32'h100);
    chk("d_first_data", inst_data, 32'hDEAD_0100);
    chk("d_next_addr", imem_addr, 32'h104);
    tick;
    inst_ready = 1'b0;
    chk("d_npop", npop, 1);

    // Redirect coinciding with ack and pop
    restart(1'b1);
    tick; tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.delete();
    tick;
    redirect_valid = 1'b0;
    chk("e_count", {29'b0, queue_count}, 32'h0);
    chk("e_valid", {31'b0, inst_valid}, 32'h0);
    chk("e_addr", imem_addr, 32'h200);
    push_exp(32'h200, 32'hDEAD_0200);
    tick;
    chk("e_head", inst_pc, 32'h200);
    tick;
    inst_ready = 1'b0;
    chk("e_npop", npop, 1);

    // Redirect from IDLE with empty queue, unaligned target, address wrap
    reset          = 1'b1;
    inst_ready     = 1'b0;
    ack_en         = 1'b1;
    exp_q.delete();
    npop           = 0;
    tick; tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    reset          = 1'b0;
    tick;
    redirect_valid = 1'b0;
    chk("f_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("f_req", {31'b0, imem_req}, 32'h1);
    push_exp(32'hFFFF_FFFC, 32'h2152_FFFC);
    push_exp(32'h0, 32'hDEAD_0000);
    tick;
    chk("f_addr_wrap", imem_addr, 32'h0);
    inst_ready = 1'b1;
    tick;
    chk("f_addr4", imem_addr, 32'h4);
    tick;
    inst_ready = 1'b0;
    chk("f_npop", npop, 2);

    chk("exp_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
